// File: rtl/ftdi_frame_loopback_if.sv
// Byte-stream handshake bundle between ftdiController and the frame loopback client.
// slave = loopback block, master = controller side.
interface ftdi_frame_loopback_if;
    logic       in_rx_hsk_req;
    logic [7:0] in_rx_data;
    logic       out_rx_hsk_ack;
    logic       out_rx_en;
    logic       out_tx_hsk_req;
    logic [7:0] out_tx_data;
    logic       in_tx_hsk_ack;

    modport slave (
        input  in_rx_hsk_req, in_rx_data, in_tx_hsk_ack,
        output out_rx_hsk_ack, out_rx_en, out_tx_hsk_req, out_tx_data
    );

    modport master (
        output in_rx_hsk_req, in_rx_data, in_tx_hsk_ack,
        input  out_rx_hsk_ack, out_rx_en, out_tx_hsk_req, out_tx_data
    );
endinterface

// File: rtl/ftdi_frame_loopback.sv
// Parses SYNC/LEN/payload/CHK host frames and echoes them back, or answers with a NAK frame.
// Optional inter-byte timeout (NAK code 3) is built when FRAME_TIMEOUT_EN is defined.
module ftdi_frame_loopback #(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SYNC_RX        = 8'hA5,
    parameter logic [7:0] SYNC_TX        = 8'h5A,
    parameter int         TIMEOUT_CYCLES = 65535
) (
    input  logic                        in_clk,
    input  logic                        in_rst,
    ftdi_frame_loopback_if.slave        bus,
    output logic                        out_busy,
    output logic                        out_err,
    output logic [1:0]                  out_err_code
);
    localparam int         IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);

    typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHK, S_TX, S_NAK} state_t;
    state_t r_state, w_nxt;

    logic             r_rx_ack, r_done, r_done_nak, r_tx_req, r_tx_wait, r_err;
    logic [1:0]       r_err_code, r_nak_code, w_err_code;
    logic [7:0]       r_len, r_chk, r_cnt, r_tx_data, w_tx_byte;
    logic [8:0]       r_tx_idx, w_tx_last_idx;
    logic [IDX_W-1:0] w_buf_idx;
    logic [7:0]       r_buf [MAX_LEN];
    logic             w_rx_st, w_parse, w_tx_st, w_accept, w_len_bad;
    logic             w_tx_step, w_tx_done, w_enter_out, w_timeout;

    assign w_parse   = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHK);
    assign w_rx_st   = w_parse || (r_state == S_HUNT);
    assign w_tx_st   = (r_state == S_TX) || (r_state == S_NAK);
    // r_done parks the parser after the last byte until its ack has fully dropped
    assign w_accept  = w_rx_st && !r_rx_ack && !r_done && bus.in_rx_hsk_req;
    assign w_len_bad = (bus.in_rx_data == 8'd0) || (bus.in_rx_data > LEN_MAX);

    assign w_tx_last_idx = (r_state == S_TX) ? ({1'b0, r_len} + 9'd2) : 9'd2;
    assign w_tx_step     = w_tx_st && r_tx_wait && !bus.in_tx_hsk_ack;
    assign w_tx_done     = w_tx_step && (r_tx_idx == w_tx_last_idx);
    assign w_buf_idx     = IDX_W'(r_tx_idx - 9'd2);

`ifdef FRAME_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            w_to_run;

    // Idle means no byte in flight: any req or ack activity restarts the count
    assign w_to_run  = w_parse && !r_done && !r_rx_ack && !bus.in_rx_hsk_req;
    assign w_timeout = w_to_run && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst)         r_to_cnt <= '0;
        else if (!w_to_run) r_to_cnt <= '0;
        else                r_to_cnt <= r_to_cnt + 1'b1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) r_state <= S_HUNT;
        else        r_state <= w_nxt;
    end

    always_comb begin
        w_nxt      = r_state;
        w_err_code = r_nak_code;
        case (r_state)
            S_HUNT: if (w_accept && bus.in_rx_data == SYNC_RX) w_nxt = S_LEN;
            S_LEN, S_PAYLOAD, S_CHK: begin
                if (r_done && !r_rx_ack) begin
                    w_nxt = r_done_nak ? S_NAK : S_TX;
                end else if (w_timeout) begin
                    w_nxt      = S_NAK;
                    w_err_code = 2'd3;
                end else if (w_accept) begin
                    if (r_state == S_LEN && !w_len_bad)                   w_nxt = S_PAYLOAD;
                    else if (r_state == S_PAYLOAD && r_cnt == r_len - 8'd1) w_nxt = S_CHK;
                end
            end
            S_TX, S_NAK: if (w_tx_done) w_nxt = S_HUNT;
            default: w_nxt = S_HUNT;
        endcase
    end

    assign w_enter_out = !w_tx_st && (w_nxt == S_TX || w_nxt == S_NAK);

    always_comb begin
        w_tx_byte = r_chk;
        if (r_tx_idx == 9'd0)                w_tx_byte = SYNC_TX;
        else if (r_tx_idx == 9'd1)           w_tx_byte = (r_state == S_TX) ? r_len : 8'h00;
        else if (r_state == S_NAK)           w_tx_byte = {6'b0, r_err_code};
        else if (r_tx_idx != w_tx_last_idx)  w_tx_byte = r_buf[w_buf_idx];
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_rx_ack   <= 1'b0;
            r_done     <= 1'b0;
            r_done_nak <= 1'b0;
            r_nak_code <= 2'd0;
            r_len      <= 8'd0;
            r_chk      <= 8'd0;
            r_cnt      <= 8'd0;
            r_tx_idx   <= 9'd0;
            r_tx_req   <= 1'b0;
            r_tx_wait  <= 1'b0;
            r_tx_data  <= 8'd0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
        end else begin
            r_err <= 1'b0;
            if (w_accept) begin
                r_rx_ack <= 1'b1;
                case (r_state)
                    S_LEN: begin
                        if (w_len_bad) begin
                            r_done     <= 1'b1;
                            r_done_nak <= 1'b1;
                            r_nak_code <= 2'd2;
                        end else begin
                            r_len <= bus.in_rx_data;
                            r_chk <= bus.in_rx_data;
                            r_cnt <= 8'd0;
                        end
                    end
                    S_PAYLOAD: begin
                        r_chk <= r_chk ^ bus.in_rx_data;
                        r_cnt <= r_cnt + 8'd1;
                    end
                    S_CHK: begin
                        r_done     <= 1'b1;
                        r_done_nak <= (bus.in_rx_data != r_chk);
                        r_nak_code <= 2'd1;
                    end
                    default: ;
                endcase
            end else if (r_rx_ack && !bus.in_rx_hsk_req) begin
                r_rx_ack <= 1'b0;
            end

            if (w_enter_out) begin
                r_done    <= 1'b0;
                r_tx_idx  <= 9'd0;
                r_tx_req  <= 1'b0;
                r_tx_wait <= 1'b0;
                if (w_nxt == S_NAK) begin
                    r_err      <= 1'b1;
                    r_err_code <= w_err_code;
                end
            end else if (w_tx_st) begin
                if (!r_tx_req && !r_tx_wait) begin
                    r_tx_req  <= 1'b1;
                    r_tx_data <= w_tx_byte;
                end else if (r_tx_req && bus.in_tx_hsk_ack) begin
                    r_tx_req  <= 1'b0;
                    r_tx_wait <= 1'b1;
                end else if (w_tx_step) begin
                    r_tx_wait <= 1'b0;
                    r_tx_idx  <= r_tx_idx + 9'd1;
                end
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (w_accept && r_state == S_PAYLOAD) r_buf[r_cnt[IDX_W-1:0]] <= bus.in_rx_data;
    end

    assign bus.out_rx_hsk_ack = r_rx_ack;
    assign bus.out_rx_en      = w_rx_st;
    assign bus.out_tx_hsk_req = r_tx_req;
    assign bus.out_tx_data    = r_tx_data;
    assign out_busy           = (r_state != S_HUNT);
    assign out_err            = r_err;
    assign out_err_code       = r_err_code;
endmodule

// File: tb/tb_ftdi_frame_loopback.sv
// Directed bench: host-side RX driver, auto-acking TX monitor with expected-byte queue.
module tb_ftdi_frame_loopback;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       out_busy, out_err;
    logic [1:0] out_err_code;

    ftdi_frame_loopback_if bus();

`ifdef FRAME_TIMEOUT_EN
    localparam int TO = 100;
`else
    localparam int TO = 65535;
`endif

    ftdi_frame_loopback #(.MAX_LEN(16), .SYNC_RX(8'hA5), .SYNC_TX(8'h5A), .TIMEOUT_CYCLES(TO)) dut (
        .in_clk(clk), .in_rst(rst), .bus(bus),
        .out_busy(out_busy), .out_err(out_err), .out_err_code(out_err_code)
    );

    always #5 clk = ~clk;

    int         checks = 0, errors = 0;
    int         cyc = 0, err_pulses = 0, req_rises = 0;
    int         ack_fall_cyc = 0, req_lat = -1, en_lat = -1;
    bit         lat_arm = 0, hold_ack = 0;
    logic       p_ack = 0, p_req = 0, p_en = 1;
    logic [7:0] exp_q[$];
    logic [7:0] stim[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // TX side: acks each byte and compares it against the expected queue
    initial begin
        forever begin
            @(negedge clk);
            if (out_err) err_pulses++;
            if (p_ack && !bus.out_rx_hsk_ack) begin ack_fall_cyc = cyc; lat_arm = 1; end
            if (lat_arm && p_en && !bus.out_rx_en) en_lat = cyc - ack_fall_cyc;
            if (!p_req && bus.out_tx_hsk_req) begin
                req_rises++;
                if (lat_arm) begin req_lat = cyc - ack_fall_cyc; lat_arm = 0; end
            end
            p_ack = bus.out_rx_hsk_ack; p_req = bus.out_tx_hsk_req; p_en = bus.out_rx_en;
            if (bus.out_tx_hsk_req && !bus.in_tx_hsk_ack && !hold_ack) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    assert (exp_q.size() != 0) else begin
                        errors++;
                        $error("FAIL tx_unexpected: observed byte %0h expected none", bus.out_tx_data);
                    end
                end else begin
                    check("tx_byte", bus.out_tx_data, exp_q.pop_front());
                end
                bus.in_tx_hsk_ack = 1'b1;
            end else if (!bus.out_tx_hsk_req && bus.in_tx_hsk_ack) begin
                bus.in_tx_hsk_ack = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        bus.in_rx_data    = b;
        bus.in_rx_hsk_req = 1'b1;
        n = 0;
        while (!bus.out_rx_hsk_ack && n < 200) begin @(posedge clk); #1; n++; end
        check("rx_ack_rise", bus.out_rx_hsk_ack, 1);
        bus.in_rx_hsk_req = 1'b0;
        n = 0;
        while (bus.out_rx_hsk_ack && n < 200) begin @(posedge clk); #1; n++; end
        check("rx_ack_fall", bus.out_rx_hsk_ack, 0);
    endtask

    task automatic send_stim();
        foreach (stim[i]) send_byte(stim[i]);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || out_busy || bus.out_tx_hsk_req || bus.in_tx_hsk_ack) && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_en"},  bus.out_rx_en, 1);
        check({tag, "_rx_ack"}, bus.out_rx_hsk_ack, 0);
        check({tag, "_tx_req"}, bus.out_tx_hsk_req, 0);
        check({tag, "_tx_data"}, bus.out_tx_data, 0);
        check({tag, "_busy"},   out_busy, 0);
        check({tag, "_err"},    out_err, 0);
        check({tag, "_code"},   out_err_code, 0);
    endtask

    initial begin
        int e0, r0, n, bad;
        bus.in_rx_hsk_req = 1'b0;
        bus.in_rx_data    = 8'h00;
        bus.in_tx_hsk_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Good frame, plus latency of rx_en fall and first TX req
        e0 = err_pulses;
        exp_q = {8'h5A, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        stim  = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_stim();
        wait_idle("frame1_drained");
        check("frame1_no_err", err_pulses - e0, 0);
        check("frame1_busy", out_busy, 0);
        check("frame1_req_lat", req_lat, 2);
        check("frame1_en_lat", en_lat, 1);

        // Junk before sync is discarded silently
        exp_q = {8'h5A, 8'h01, 8'h7E, 8'h7F};
        send_byte(8'hFF);
        check("hunt_discard_busy", out_busy, 0);
        stim = {8'h00, 8'hA5, 8'h01, 8'h7E, 8'h7F};
        send_stim();
        wait_idle("frame2_drained");
        check("frame2_no_err", err_pulses - e0, 0);

        // Bad checksum
        exp_q = {8'h5A, 8'h00, 8'h01};
        stim  = {8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
        send_stim();
        wait_idle("badchk_drained");
        check("badchk_err_pulses", err_pulses - e0, 1);
        check("badchk_code", out_err_code, 1);
        check("badchk_req_lat", req_lat, 2);

        // Length 0 and length MAX_LEN+1
        exp_q = {8'h5A, 8'h00, 8'h02};
        stim  = {8'hA5, 8'h00};
        send_stim();
        wait_idle("len0_drained");
        check("len0_code", out_err_code, 2);
        exp_q = {8'h5A, 8'h00, 8'h02};
        stim  = {8'hA5, 8'h11};
        send_stim();
        wait_idle("len17_drained");
        check("len_err_pulses", err_pulses - e0, 3);
        exp_q = {8'h5A, 8'h01, 8'h55, 8'h54};
        stim  = {8'hA5, 8'h01, 8'h55, 8'h54};
        send_stim();
        wait_idle("len1_drained");
        check("code_held", out_err_code, 2);

        // TX stall: held req/data, RX ignored, then reset mid-TX
        hold_ack = 1;
        exp_q = {8'h5A, 8'h02, 8'hAA, 8'hBB, 8'h13};
        stim  = {8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h13};
        send_stim();
        n = 0;
        while (!bus.out_tx_hsk_req && n < 100) begin @(posedge clk); #1; n++; end
        check("stall_req_up", bus.out_tx_hsk_req, 1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            bus.in_rx_data    = 8'hA5;
            bus.in_rx_hsk_req = ((i % 2) == 1);
            @(posedge clk); #1;
            if (bus.out_tx_data !== 8'h5A || bus.out_tx_hsk_req !== 1'b1 ||
                bus.out_rx_en !== 1'b0 || bus.out_rx_hsk_ack !== 1'b0) bad++;
        end
        check("stall_violations", bad, 0);
        bus.in_rx_hsk_req = 1'b0;
        #3 rst = 1'b1;
        #1;
        check_reset_outputs("midtx_reset");
        exp_q.delete();
        hold_ack = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        exp_q = {8'h5A, 8'h01, 8'hC3, 8'hC2};
        stim  = {8'hA5, 8'h01, 8'hC3, 8'hC2};
        send_stim();
        wait_idle("recover_drained");

`ifdef FRAME_TIMEOUT_EN
        exp_q = {8'h5A, 8'h00, 8'h03};
        stim  = {8'hA5, 8'h04, 8'h01};
        send_stim();
        wait_idle("timeout_drained");
        check("timeout_code", out_err_code, 3);
`else
        r0 = req_rises;
        stim = {8'hA5, 8'h04, 8'h01};
        send_stim();
        repeat (10000) @(posedge clk);
        #1;
        check("no_timeout_tx", req_rises - r0, 0);
        check("no_timeout_busy", out_busy, 1);
        exp_q = {8'h5A, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
        stim  = {8'h02, 8'h03, 8'h04, 8'h00};
        send_stim();
        wait_idle("late_frame_drained");
        check("late_frame_code", out_err_code, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
